ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Iterative RV32M sequencer next to the EX stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//  op from EX and runs a radix-2 shift-add multiply or restoring divide over 32 cycles.
//  Stalls the pipeline while busy and returns a one-cycle result beat that EX muxes onto its result bus.
//  Owns the stall request for M-ops and handles div-by-zero/overflow without iterating.
// PARAMETERS
//  XLEN       32  operand/result width (only 32 supported)
//  EARLY_OUT  1   1: div-by-zero and signed overflow bypass CALC, finish in 1 cycle; 0: iterate anyway
// PORTS
//  clk_i      in   1     clock, all state on rising edge
//  rst_ni     in   1     synchronous reset, active-low
//  start_i    in   1     valid M-op in EX; held stable by the pipeline while stall_o=1
//  funct3_i   in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  rs1_i      in   XLEN  operand A (dividend / multiplicand)
//  rs2_i      in   XLEN  operand B (divisor / multiplier)
//  flush_i    in   1     kill in-flight op (branch/jump redirect from EX)
//  stall_o    out  1     hold IF/ID/EX
//  done_o     out  1     one-cycle result-valid pulse
//  res_o      out  XLEN  result; valid only when done_o=1, else 0
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state=IDLE, counter=0, accumulators=0; done_o=0, res_o=0, stall_o=0
//   while in reset. Reset mid-op aborts silently, no done_o.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE: start_i=1 & flush_i=0 -> latch funct3, signs, |rs1|,|rs2| (signedness per funct3);
//         go CALC (or DONE if early-out case & EARLY_OUT=1). stall_o = start_i & ~flush_i (comb).
//   CALC: one iteration/cycle, counter 0..31; at counter=31 -> FIX. stall_o=1.
//   FIX : apply sign correction, select hi/lo or quotient/remainder into result reg -> DONE. stall_o=1.
//   DONE: done_o=1, res_o=result, stall_o=0 (pipeline advances this cycle); start_i ignored;
//         -> IDLE unconditionally. A back-to-back M-op is accepted the following IDLE cycle.
//  Latency: start accepted in cycle 0 -> done_o in cycle 34 (32 CALC + FIX + DONE).
//   Early-out: done_o in cycle 1.
//  Multiply: 64-bit product of magnitudes; negate if signs differ (MULH: both signed; MULHSU: rs1 only).
//   MUL returns prod[31:0]; MULH/MULHSU/MULHU return prod[63:32].
//  Divide: restoring, 32 quotient bits MSB first; quotient negated if signs differ (DIV);
//   remainder takes dividend sign (REM).
//  Special cases (RISC-V mandated):
//   rs2=0:            DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
//   0x80000000/-1 (signed): DIV -> 0x80000000, REM -> 0.
//   With EARLY_OUT=0 the iterated path produces identical values.
//  flush_i: highest priority after reset; from any state -> IDLE next edge, done_o forced 0 that cycle,
//   stall_o=0 in that cycle. flush_i with start_i in IDLE: op not accepted.
//  stall_o and done_o never both 1. Operands sampled only at acceptance; later rs1_i/rs2_i changes ignored.
// TESTING
//  MUL 7 * 0xFFFFFFFD -> done_o at cycle 34, res_o=0xFFFFFFEB; stall_o high cycles 0..33.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIVU 0x1234/0 -> 0xFFFFFFFF at cycle 1; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//  DIV started, flush_i at cycle 10 -> IDLE at 11, no done_o; new MUL 3*5 at 12 -> 15 at cycle 46.
//  rst_ni=0 at cycle 20 of DIVU -> outputs 0, IDLE; back-to-back MUL ops: second accepted cycle after DONE.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer beside the EX stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with a single-cycle result beat and pipeline stall ownership.
module ex_muldiv_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PROD_W = 2 * XLEN;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN - 1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             div_zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  acc_hi_q;
    logic [XLEN-1:0]  acc_lo_q;
    logic [XLEN-1:0]  opb_q;
    logic [XLEN-1:0]  result_q;

    // Operand decode at acceptance: signedness, magnitudes, special cases
    logic            is_div_in;
    logic            a_signed_in;
    logic            b_signed_in;
    logic            sign_a_in;
    logic            sign_b_in;
    logic [XLEN-1:0] mag_a_in;
    logic [XLEN-1:0] mag_b_in;
    logic            div_zero_in;
    logic            div_ovf_in;
    logic            early_in;
    logic [XLEN-1:0] early_res;

    assign is_div_in   = funct3_i[2];
    assign a_signed_in = (funct3_i == F_MULH) || (funct3_i == F_MULHSU) ||
                         (funct3_i == F_DIV)  || (funct3_i == F_REM);
    assign b_signed_in = (funct3_i == F_MULH) || (funct3_i == F_DIV) || (funct3_i == F_REM);
    assign sign_a_in   = a_signed_in & rs1_i[XLEN-1];
    assign sign_b_in   = b_signed_in & rs2_i[XLEN-1];
    assign mag_a_in    = sign_a_in ? (~rs1_i + XLEN'(1)) : rs1_i;
    assign mag_b_in    = sign_b_in ? (~rs2_i + XLEN'(1)) : rs2_i;
    assign div_zero_in = is_div_in && (rs2_i == '0);
    assign div_ovf_in  = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
                         (rs1_i == INT_MIN) && (rs2_i == '1);
    assign early_in    = EARLY_OUT && (div_zero_in || div_ovf_in);

    // REM/REMU have funct3[1] set; DIV/DIVU do not
    assign early_res = funct3_i[1] ? (div_zero_in ? rs1_i : '0)
                                   : (div_zero_in ? '1 : INT_MIN);

    // One shift-add multiply step
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : '0)};

    // One restoring divide step; remainder stays below divisor so XLEN bits hold the difference
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    assign rem_sh  = {acc_hi_q, acc_lo_q[XLEN-1]};
    assign div_ge  = rem_sh >= {1'b0, opb_q};
    assign div_sub = rem_sh[XLEN-1:0] - opb_q;

    // Sign correction and result selection
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fix_res;

    assign prod   = {acc_hi_q, acc_lo_q};
    assign prod_s = (sign_a_q ^ sign_b_q) ? (~prod + PROD_W'(1)) : prod;
    // Divide-by-zero must give all ones regardless of dividend sign
    assign quo_s  = ((sign_a_q ^ sign_b_q) && !div_zero_q) ? (~acc_lo_q + XLEN'(1)) : acc_lo_q;
    assign rem_s  = sign_a_q ? (~acc_hi_q + XLEN'(1)) : acc_hi_q;

    // Pick the architectural result for the latched op
    always_comb begin
        fix_res = '0;
        case (op_q)
            F_MUL:                     fix_res = prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: fix_res = prod_s[PROD_W-1:XLEN];
            F_DIV, F_DIVU:             fix_res = quo_s;
            F_REM, F_REMU:             fix_res = rem_s;
            default:                   fix_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; flush and reset override everything
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        res_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stall_o = 1'b1;
                    state_d = early_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                stall_o = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                res_o   = result_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i || !rst_ni) begin
            state_d = S_IDLE;
            stall_o = 1'b0;
            done_o  = 1'b0;
            res_o   = '0;
        end
    end

    // Datapath: operand capture, iteration, result latch
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opb_q      <= '0;
            result_q   <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q       <= funct3_i;
                        sign_a_q   <= sign_a_in;
                        sign_b_q   <= sign_b_in;
                        div_zero_q <= div_zero_in;
                        cnt_q      <= '0;
                        acc_hi_q   <= '0;
                        acc_lo_q   <= is_div_in ? mag_a_in : mag_b_in;
                        opb_q      <= is_div_in ? mag_b_in : mag_a_in;
                        result_q   <= early_res;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (op_q[2]) begin
                        acc_hi_q <= div_ge ? div_sub : rem_sh[XLEN-1:0];
                        acc_lo_q <= {acc_lo_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_hi_q <= mul_sum[XLEN:1];
                        acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: latency/result model plus directed literals.
module tb_ex_muldiv_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  f3    = 3'd0;
    logic [31:0] rs1   = 32'd0;
    logic [31:0] rs2   = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] res;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int done_pulses = 0;

    ex_muldiv_ctrl #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .funct3_i (f3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .stall_o  (stall),
        .done_o   (done),
        .res_o    (res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural result from RISC-V M-extension rules using 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // Model: cycles remaining until the result beat (0 = idle, 1 = beat cycle)
    int          rem_cyc = 0;
    logic [31:0] m_res   = 32'd0;

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            rem_cyc <= 0;
        end else if (rem_cyc == 0) begin
            if (start) begin
                rem_cyc <= is_early(f3, rs1, rs2) ? 1 : 34;
                m_res   <= ref_res(f3, rs1, rs2);
            end
        end else begin
            rem_cyc <= rem_cyc - 1;
        end
    end

    // Per-cycle comparison of every output against the model
    logic        e_done;
    logic        e_stall;
    logic [31:0] e_res;

    always @(negedge clk) begin
        e_done  = rst_n && !flush && (rem_cyc == 1);
        e_stall = rst_n && !flush && ((rem_cyc > 1) || ((rem_cyc == 0) && start));
        e_res   = e_done ? m_res : 32'd0;
        check("cyc_stall", {31'd0, stall}, {31'd0, e_stall});
        check("cyc_done", {31'd0, done}, {31'd0, e_done});
        check("cyc_res", res, e_res);
        check("cyc_excl", {31'd0, stall & done}, 32'd0);
        if (done) done_pulses++;
    end

    // Issue one op at the next cycle, wait for its beat; leaves start asserted
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int lat, input string name);
        int          n;
        int          st;
        logic        got;
        logic [31:0] r;
        n   = 0;
        st  = 0;
        got = 1'b0;
        r   = 32'd0;
        check({name, "_model"}, ref_res(f, a, b), lit);
        @(posedge clk); #1;
        start = 1'b1; f3 = f; rs1 = a; rs2 = b;
        while (!got && n < 60) begin
            @(negedge clk);
            if (stall) st++;
            if (done) begin
                got = 1'b1;
                r   = res;
            end else begin
                @(posedge clk); #1;
                n++;
                rs1 = ~a;
                rs2 = b ^ 32'h5A5A_5A5A;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done_o within %0d cycles, required at %0d", name, n, lat);
        end else begin
            check({name, "_res"}, r, lit);
            check({name, "_lat"}, n, lat);
            check({name, "_stall"}, st, lat);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int dp0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_res", res, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff");
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_ff");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ff");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
        do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34, "mulhsu_min");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, "div_m7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, "rem_m7_2");
        do_op(3'd5, 32'd100,        32'd7,          32'd14,        34, "divu_100_7");
        do_op(3'd7, 32'd100,        32'd7,          32'd2,         34, "remu_100_7");
        do_op(3'd4, 32'h8000_0000, 32'd2,          32'hC000_0000, 34, "div_min_2");
        do_op(3'd5, 32'h8000_0000, 32'd2,          32'h4000_0000, 34, "divu_min_2");
        do_op(3'd5, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF, 1,  "divu_zero");
        do_op(3'd6, 32'h0000_1234, 32'd0,          32'h0000_1234, 1,  "rem_zero");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF, 1,  "div_neg_zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");

        // Flush mid-divide: abort with no beat, then a fresh multiply
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'd4; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
        dp0 = done_pulses;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_stall", {31'd0, stall}, 32'd0);
        check("flush_no_done", done_pulses - dp0, 32'd0);
        do_op(3'd0, 32'd3, 32'd5, 32'd15, 34, "mul_after_flush");

        // Flush together with start in IDLE must not accept the op
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        check("flush_start_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle", {31'd0, stall}, 32'd0);

        // Flush during the result beat suppresses it
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'd5; rs1 = 32'd5; rs2 = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_beat_done", {31'd0, done}, 32'd0);
        check("flush_beat_res", res, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;

        // Reset mid-divide aborts silently
        @(posedge clk); #1;
        start = 1'b1; f3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_res", res, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_stall", {31'd0, stall}, 32'd0);

        // Back-to-back: second op accepted the cycle after the beat
        do_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34, "b2b_mul");
        do_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, "b2b_mulhu");
        do_op(3'd0, 32'd6,          32'd7,          32'd42,        34, "b2b_mul42");

        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
